// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the single-port memory bus between instruction fetch and the MEM-stage load/store path
module dbus_arbiter #(
  parameter int XLEN          = 32,
  parameter int LS_MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_flush,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [XLEN/8-1:0] ls_wstrb,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              load_hand_suc,
  output logic              store_hand_suc,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);
  localparam int CW = $clog2(LS_MAX_CONSEC + 1);
  localparam logic [CW-1:0] CMAX = CW'(LS_MAX_CONSEC);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic owner_ls, squash, arb, ls_win, resp;
  logic [CW-1:0] cnt;
  // state register; async reset abandons any outstanding transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // arbitration, next state and response routing
  always_comb begin
    arb            = state == IDLE && !pipe_flush && (if_req || ls_req);
    ls_win         = ls_req && !(if_req && cnt == CMAX);
    state_nx       = state == IDLE ? (arb ? REQ : IDLE) :
                     state == REQ  ? (bus_gnt ? WAIT : pipe_flush ? IDLE : REQ) :
                                     (bus_rvalid ? IDLE : WAIT);
    bus_req        = state == REQ;
    if_gnt         = bus_req && bus_gnt && !pipe_flush && !owner_ls;
    ls_gnt         = bus_req && bus_gnt && !pipe_flush && owner_ls;
    resp           = state == WAIT && bus_rvalid && !squash && !pipe_flush;
    if_rvalid      = resp && !owner_ls;
    ls_rvalid      = resp && owner_ls;
    if_rdata       = if_rvalid ? bus_rdata : '0;
    ls_rdata       = ls_rvalid ? bus_rdata : '0;
    load_hand_suc  = ls_rvalid && !bus_we;
    store_hand_suc = ls_rvalid && bus_we;
  end
  // latch the winner onto the bus, track fairness and squash of flushed transactions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner_ls  <= 1'b0;
      squash    <= 1'b0;
      cnt       <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else begin
      if (arb) begin
        owner_ls  <= ls_win;
        bus_we    <= ls_win && ls_we;
        bus_addr  <= ls_win ? ls_addr : if_addr;
        bus_wdata <= ls_win ? ls_wdata : '0;
        bus_wstrb <= ls_win ? ls_wstrb : '1;
        cnt       <= !(ls_win && if_req) ? '0 : cnt == CMAX ? CMAX : cnt + 1'b1;
      end
      squash <= state == REQ  ? (bus_gnt && pipe_flush) :
                state == WAIT ? (!bus_rvalid && (squash || pipe_flush)) : 1'b0;
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: scoreboard-driven bench for dbus_arbiter
module tb_dbus_arbiter;
  logic clk = 0, rst_n = 1, pipe_flush = 0, if_req = 0, ls_req = 0, ls_we = 0;
  logic bus_gnt = 0, bus_rvalid = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, bus_rdata = 0;
  logic [3:0] ls_wstrb = 0;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, load_hand_suc, store_hand_suc, bus_req, bus_we;
  logic [31:0] if_rdata, ls_rdata, bus_addr, bus_wdata;
  logic [3:0] bus_wstrb;
  logic [139:0] all_outs;
  int total = 0, bad = 0;
  typedef struct {logic ls; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [31:0] rdata;} exp_t;
  exp_t sbq[$];

  dbus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .load_hand_suc(load_hand_suc), .store_hand_suc(store_hand_suc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  assign all_outs = {bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, if_gnt, if_rvalid, if_rdata,
                     ls_gnt, ls_rvalid, ls_rdata, load_hand_suc, store_hand_suc};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [138:0] expv(exp_t e);
    return {!e.ls, e.ls, !e.ls, e.ls, e.ls && !e.we, e.ls && e.we, e.we, e.addr, e.wdata, e.wstrb,
            e.ls ? 32'h0 : e.rdata, e.ls ? e.rdata : 32'h0};
  endfunction

  // plays a bus slave for one transaction and records what the arbiter showed
  task automatic do_txn(input int gdly, input logic [31:0] rdat, output logic [138:0] obs, output logic [23:0] tim);
    int lat = 0, rc = 0, stray = 0;
    logic ig, lg, w;
    logic [31:0] a, wd;
    logic [3:0] ws;
    while (!bus_req && lat < 10) begin
      step;
      lat++;
    end
    w = bus_we; a = bus_addr; wd = bus_wdata; ws = bus_wstrb;
    rc = int'(bus_req);
    for (int i = 0; i < gdly; i++) begin
      if (if_gnt | ls_gnt | if_rvalid | ls_rvalid) stray++;
      step;
      if (bus_req) rc++;
      if (bus_addr !== a) stray++;
    end
    bus_gnt = 1;
    #1;
    ig = if_gnt; lg = ls_gnt;
    if (ig) if_req = 0;
    if (lg) ls_req = 0;
    step;
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = rdat;
    #1;
    if (bus_req | if_gnt | ls_gnt) stray++;
    obs = {ig, lg, if_rvalid, ls_rvalid, load_hand_suc, store_hand_suc, w, a, wd, ws, if_rdata, ls_rdata};
    step;
    if (if_rvalid | ls_rvalid) stray++;
    bus_rvalid = 0; bus_rdata = 0;
    tim = {lat[7:0], rc[7:0], stray[7:0]};
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    step;
    total++;
    if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_idle: bus_req got %b want 0", bus_req); end
  endtask

  task automatic test_if_only;
    exp_t e;
    logic [138:0] obs;
    logic [23:0] tim;
    if_addr = 32'h8000_0000; if_req = 1;
    sbq.push_back('{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'h0000_0013});
    do_txn(2, 32'h0000_0013, obs, tim);
    e = sbq.pop_front();
    total++;
    if (obs !== expv(e)) begin bad++; $display("FAIL if_only txn: got %h want %h", obs, expv(e)); end
    total++;
    if (tim !== {8'd1, 8'd3, 8'd0}) begin bad++; $display("FAIL if_only timing: got %h want 010300", tim); end
  endtask

  task automatic test_simultaneous;
    exp_t e;
    logic [138:0] obs;
    logic [23:0] tim;
    ls_addr = 32'h1000; ls_we = 0; ls_wdata = 0; ls_wstrb = 4'hF; ls_req = 1;
    if_addr = 32'h8000_0004; if_req = 1;
    sbq.push_back('{1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, 32'hCAFE_0001});
    sbq.push_back('{1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'hF, 32'h0000_0093});
    do_txn(0, 32'hCAFE_0001, obs, tim);
    e = sbq.pop_front();
    total++;
    if (obs !== expv(e)) begin bad++; $display("FAIL simul_ls txn: got %h want %h", obs, expv(e)); end
    total++;
    if (tim !== {8'd1, 8'd1, 8'd0}) begin bad++; $display("FAIL simul_ls timing: got %h want 010100", tim); end
    do_txn(0, 32'h0000_0093, obs, tim);
    e = sbq.pop_front();
    total++;
    if (obs !== expv(e)) begin bad++; $display("FAIL simul_if txn: got %h want %h", obs, expv(e)); end
    total++;
    if (tim !== {8'd1, 8'd1, 8'd0}) begin bad++; $display("FAIL simul_if timing: got %h want 010100", tim); end
  endtask

  task automatic test_store;
    exp_t e;
    logic [138:0] obs;
    logic [23:0] tim;
    ls_we = 1; ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'h3; ls_req = 1;
    sbq.push_back('{1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'h3, 32'h0});
    do_txn(1, 32'h0, obs, tim);
    e = sbq.pop_front();
    total++;
    if (obs !== expv(e)) begin bad++; $display("FAIL store txn: got %h want %h", obs, expv(e)); end
    total++;
    if (tim !== {8'd1, 8'd2, 8'd0}) begin bad++; $display("FAIL store timing: got %h want 010200", tim); end
    ls_we = 0; ls_wdata = 0; ls_wstrb = 4'hF;
  endtask

  task automatic test_fairness;
    exp_t e;
    logic [138:0] obs;
    logic [23:0] tim;
    logic own_ls;
    ls_addr = 32'h3000; ls_we = 0; ls_wstrb = 4'hF;
    if_addr = 32'h0000_0100; if_req = 1;
    for (int k = 0; k < 8; k++) begin
      if (k < 7) ls_req = 1;
      if (k == 6) if_req = 1;
      own_ls = (k != 4) && (k != 7);
      sbq.push_back('{own_ls, 1'b0, own_ls ? 32'h3000 : 32'h100, 32'h0, 4'hF, 32'hA000_0000 + k});
      do_txn(0, 32'hA000_0000 + k, obs, tim);
      e = sbq.pop_front();
      total++;
      if (obs !== expv(e)) begin bad++; $display("FAIL fairness txn %0d: got %h want %h", k, obs, expv(e)); end
      total++;
      if (tim !== {8'd1, 8'd1, 8'd0}) begin bad++; $display("FAIL fairness timing %0d: got %h want 010100", k, tim); end
    end
  endtask

  task automatic test_flush;
    exp_t e;
    logic [138:0] obs;
    logic [23:0] tim;
    if_addr = 32'h200; if_req = 1; pipe_flush = 1;
    step;
    total++;
    if (bus_req !== 1'b0) begin bad++; $display("FAIL flush_idle: bus_req got %b want 0", bus_req); end
    pipe_flush = 0; if_req = 0;
    step;
    ls_addr = 32'h4000; ls_we = 0; ls_req = 1;
    step;
    total++;
    if (bus_req !== 1'b1) begin bad++; $display("FAIL flush_req_enter: bus_req got %b want 1", bus_req); end
    pipe_flush = 1; ls_req = 0;
    #1;
    total++;
    if ({if_gnt, ls_gnt} !== 2'b00) begin bad++; $display("FAIL flush_req_gnt: got %b want 00", {if_gnt, ls_gnt}); end
    step;
    pipe_flush = 0;
    total++;
    if (bus_req !== 1'b0) begin bad++; $display("FAIL flush_req_drop: bus_req got %b want 0", bus_req); end
    ls_req = 1;
    step;
    pipe_flush = 1; bus_gnt = 1; ls_req = 0;
    #1;
    total++;
    if (ls_gnt !== 1'b0) begin bad++; $display("FAIL flush_gnt_same: ls_gnt got %b want 0", ls_gnt); end
    step;
    pipe_flush = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h77;
    #1;
    total++;
    if ({bus_req, ls_rvalid, load_hand_suc, ls_rdata} !== 35'h0) begin
      bad++; $display("FAIL flush_gnt_drain: got %h want 0", {bus_req, ls_rvalid, load_hand_suc, ls_rdata});
    end
    step;
    bus_rvalid = 0; bus_rdata = 0;
    ls_req = 1;
    step;
    bus_gnt = 1;
    #1;
    total++;
    if (ls_gnt !== 1'b1) begin bad++; $display("FAIL flush_wait_gnt: ls_gnt got %b want 1", ls_gnt); end
    ls_req = 0;
    step;
    bus_gnt = 0; pipe_flush = 1;
    #1;
    total++;
    if (ls_rvalid !== 1'b0) begin bad++; $display("FAIL flush_wait_hold: ls_rvalid got %b want 0", ls_rvalid); end
    step;
    pipe_flush = 0; bus_rvalid = 1; bus_rdata = 32'h88;
    #1;
    total++;
    if ({ls_rvalid, load_hand_suc, store_hand_suc, ls_rdata} !== 35'h0) begin
      bad++; $display("FAIL flush_wait_drain: got %h want 0", {ls_rvalid, load_hand_suc, store_hand_suc, ls_rdata});
    end
    step;
    bus_rvalid = 0; bus_rdata = 0;
    ls_we = 1; ls_addr = 32'h6000; ls_wdata = 32'h1234_5678; ls_wstrb = 4'hC; ls_req = 1;
    sbq.push_back('{1'b1, 1'b1, 32'h6000, 32'h1234_5678, 4'hC, 32'h0});
    do_txn(0, 32'h0, obs, tim);
    e = sbq.pop_front();
    total++;
    if (obs !== expv(e)) begin bad++; $display("FAIL flush_after txn: got %h want %h", obs, expv(e)); end
    total++;
    if (tim !== {8'd1, 8'd1, 8'd0}) begin bad++; $display("FAIL flush_after timing: got %h want 010100", tim); end
    ls_we = 0; ls_wdata = 0; ls_wstrb = 4'hF;
  endtask

  task automatic test_reset_mid;
    if_addr = 32'h300; if_req = 1;
    step;
    bus_gnt = 1;
    #1;
    total++;
    if (if_gnt !== 1'b1) begin bad++; $display("FAIL rst_mid_gnt: if_gnt got %b want 1", if_gnt); end
    if_req = 0;
    step;
    bus_gnt = 0;
    rst_n = 0;
    #1;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL rst_mid_outputs: got %h want 0", all_outs); end
    @(posedge clk);
    #3 rst_n = 1;
    step;
    bus_rvalid = 1; bus_rdata = 32'h99;
    #1;
    total++;
    if ({bus_req, if_rvalid, if_rdata} !== 34'h0) begin
      bad++; $display("FAIL rst_mid_stray: got %h want 0", {bus_req, if_rvalid, if_rdata});
    end
    step;
    bus_rvalid = 0; bus_rdata = 0;
  endtask

  initial begin
    test_reset;
    test_if_only;
    test_simultaneous;
    test_store;
    test_fairness;
    test_flush;
    test_reset_mid;
    total++;
    if (sbq.size() !== 0) begin bad++; $display("FAIL scoreboard_empty: got %0d left want 0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single-port core memory bus between instruction fetch (IF) and the load/store path of the MEM stage.
- Arbitrates requests and drives one transaction at a time on the bus (address phase, then response phase).
- Routes the response back to the requester that owns the transaction.
- Generates the load_hand_suc/store_hand_suc completion pulses that hold the MEM stage until its access finishes.

Parameters:
- XLEN, 32, data/address width.
- LS_MAX_CONSEC, 4, max consecutive LS grants while if_req is pending before IF wins once.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_flush  in  1  pipeline flush; squashes pending/outstanding transactions
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch address accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  XLEN  fetch data
- ls_req  in  1  load/store request; held with fields stable until ls_gnt
- ls_we  in  1  1=store, 0=load
- ls_addr  in  XLEN  data address
- ls_wdata  in  XLEN  store data
- ls_wstrb  in  XLEN/8  byte strobes
- ls_gnt  out  1  data address accepted (pulse)
- ls_rvalid  out  1  data response valid (pulse)
- ls_rdata  out  XLEN  load data
- load_hand_suc  out  1  ls_rvalid & load
- store_hand_suc  out  1  ls_rvalid & store
- bus_req  out  1  bus address-phase request
- bus_we  out  1  bus write enable
- bus_addr  out  XLEN  bus address
- bus_wdata  out  XLEN  bus write data
- bus_wstrb  out  XLEN/8  bus strobes (all-ones for fetch)
- bus_gnt  in  1  slave accepted address phase
- bus_rvalid  in  1  slave response valid
- bus_rdata  in  XLEN  slave read data

Behaviour:
- Reset values: state IDLE; owner IF; squash 0; consec count 0.
  - All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, both gnt/rvalid pulses, both rdata, both hand_suc.
- FSM states: IDLE, REQ (address phase), WAIT (response phase). Exactly one transaction outstanding at any time.
- IDLE:
  - If pipe_flush=1, no request is latched and state stays IDLE.
  - Else if any request is present, select the owner:
    - LS wins if ls_req=1 and not (if_req=1 and count==LS_MAX_CONSEC).
    - Otherwise IF wins.
  - Latch the owner's addr/we/wdata/wstrb into the bus_* registers and go to REQ.
  - Fetch latches bus_we=0 and bus_wstrb all-ones.
  - Latency: request seen in cycle n -> bus_req=1 in cycle n+1.
- Fairness counter:
  - Increments when LS is granted while if_req=1, saturating at LS_MAX_CONSEC.
  - Clears on any IF grant or when if_req=0 at arbitration.
- REQ:
  - bus_req=1; bus_* held stable.
  - On bus_gnt=1: combinational pulse on the owner's gnt (if_gnt or ls_gnt = bus_gnt in REQ with matching owner); bus_req drops next cycle; go to WAIT.
  - pipe_flush=1 without bus_gnt: abandon -> IDLE, bus_req=0 next cycle, no gnt pulse.
  - pipe_flush=1 with bus_gnt in the same cycle: address already accepted -> set squash=1, go to WAIT, gnt pulse suppressed.
- WAIT:
  - bus_req=0.
  - On bus_rvalid=1: if squash=0, pulse the owner's rvalid; rdata = bus_rdata (combinational pass-through, same cycle).
  - For an LS owner, load_hand_suc=!bus_we or store_hand_suc=bus_we in the same cycle.
  - Then go to IDLE and clear squash.
  - pipe_flush=1 in WAIT sets squash=1: the transaction is drained, no rvalid/hand_suc.
  - pipe_flush coincident with bus_rvalid also suppresses the pulses.
- Back-to-back: no rearbitration in WAIT; a new request is handled in IDLE the cycle after completion. Minimum 3 cycles per transaction (IDLE, REQ, WAIT).
- Non-owner outputs are always 0. if_rdata and ls_rdata are 0 when their rvalid is 0.
- Requester dropping req before gnt is illegal (not checked). bus_rvalid outside WAIT is ignored.
- Async reset mid-transaction returns to reset values immediately; no response is delivered.

Test Plan:
- IF only: if_req=1, addr 0x80000000, bus_gnt after 2 cycles, rvalid 1 cycle later with 0x00000013 -> bus_req cycles 1-3, if_gnt pulses with bus_gnt, if_rdata=0x00000013 with if_rvalid, ls_* stay 0.
- Simultaneous: if_req and ls_req (load 0x1000) both asserted, bus_gnt=bus_rvalid=1 immediately -> LS served first, load_hand_suc=1 once, then IF transaction starts in the next IDLE.
- Fairness: ls_req held continuously, if_req held, LS_MAX_CONSEC=4 -> exactly 4 LS grants, then 1 IF grant, then LS resumes; counter clears.
- Store: ls_we=1, addr 0x2004, wdata 0xDEADBEEF, wstrb 0x3 -> bus_we=1, bus_wstrb=0x3, bus_wdata=0xDEADBEEF; store_hand_suc pulses with bus_rvalid, load_hand_suc=0.
- Flush in REQ: pipe_flush while bus_gnt=0 -> bus_req=0 next cycle, no gnt/rvalid. Flush in WAIT -> bus_rvalid consumed, no ls_rvalid/hand_suc, next request arbitrated normally.
- Reset mid-WAIT: rst_n low -> all outputs 0 asynchronously; a stray bus_rvalid after release is ignored.
